// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: op encodings, FSM states, helpers.
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;
    localparam logic [2:0] DIV_OP_REM  = 3'b110;
    localparam logic [2:0] DIV_OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

endpackage

// File: rtl/mdu_divider_if.sv
// Request/response bundle between the decoder/execute stage and the divider.
interface mdu_divider_if #(
    parameter int unsigned XLEN = 32
);
    logic            div_start;
    logic [2:0]      div_op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output div_start, div_op, dividend, divisor, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  div_start, div_op, dividend, divisor, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed 33-cycle latency on the normal path; divide-by-zero and overflow finish in one.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         rst_n,
    mdu_divider_if.slave bus
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_out_q, rd_out_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             sign_a, sign_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  step_rem, step_quo;

    // One restoring step: the remainder picks up the next dividend bit, and the quotient bit
    // shifts in from the right as the dividend bits shift out the left of the same register.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dsr);
        logic [XLEN:0] acc;
        logic [XLEN:0] diff;
        acc  = {rem, quo[XLEN-1]};
        diff = acc - {1'b0, dsr};
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        end
        return {acc[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    assign accept = bus.div_start && bus.div_op[2] && !bus.flush;
    assign sign_a = op_is_signed(bus.div_op) && bus.dividend[XLEN-1];
    assign sign_b = op_is_signed(bus.div_op) && bus.divisor[XLEN-1];
    assign abs_a  = sign_a ? -bus.dividend : bus.dividend;
    assign abs_b  = sign_b ? -bus.divisor : bus.divisor;
    assign {step_rem, step_quo} = div_step(rem_q, quo_q, dsr_q);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        rd_d      = rd_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        if (op_is_rem(op_q)) begin
                            result_d = neg_rem_q ? -step_rem : step_rem;
                        end else begin
                            result_d = neg_quo_q ? -step_quo : step_quo;
                        end
                        rd_out_d = rd_q;
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d = bus.div_op;
                    rd_d = bus.rd_in;
                    if (bus.divisor == '0) begin
                        result_d = op_is_rem(bus.div_op) ? bus.dividend : '1;
                        rd_out_d = bus.rd_in;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else if (op_is_signed(bus.div_op) && bus.dividend == MinNeg &&
                                 bus.divisor == '1) begin
                        result_d = op_is_rem(bus.div_op) ? '0 : MinNeg;
                        rd_out_d = bus.rd_in;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else begin
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        quo_d     = abs_a;
                        dsr_d     = abs_b;
                        rem_d     = '0;
                        cnt_d     = CNT_W'(XLEN - 1);
                        state_d   = CALC;
                        busy_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: latency, results, special cases, flush, back-to-back, reset.
module tb_mdu_divider;
    import mdu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mdu_divider_if #(.XLEN(32)) bus ();

    mdu_divider #(
        .XLEN (32),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        bus.div_op    = op;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.rd_in     = rd;
        bus.div_start = 1'b1;
    endtask

    // Called in cycle 0 (start asserted); returns at the negedge of the done cycle, lat=0 if none.
    task automatic wait_done(input int inject_at, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            if (k == inject_at) begin
                drive_start(DIV_OP_DIVU, 32'd1, 32'd1, 5'd3);
            end else begin
                bus.div_start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int bcnt);
        @(negedge clk);
        drive_start(op, a, b, rd);
        wait_done(0, lat, bcnt);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    vec_t vecs[14];
    int   lat;
    int   bcnt;
    int   ndone;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        bus.div_start = 1'b0;
        bus.div_op    = 3'b000;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        rst_n         = 1'b0;

        vecs[0]  = '{DIV_OP_DIV,  32'd100,      32'd7,        5'd5,  32'd14,       33};
        vecs[1]  = '{DIV_OP_REM,  32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFFE, 33};
        vecs[2]  = '{DIV_OP_DIVU, 32'hFFFFFFFF, 32'd2,        5'd7,  32'h7FFFFFFF, 33};
        vecs[3]  = '{DIV_OP_REMU, 32'hFFFFFFFF, 32'd16,       5'd8,  32'h0000000F, 33};
        vecs[4]  = '{DIV_OP_DIVU, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1};
        vecs[5]  = '{DIV_OP_REM,  32'd5,        32'd0,        5'd10, 32'd5,        1};
        vecs[6]  = '{DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        vecs[7]  = '{DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1};
        vecs[8]  = '{DIV_OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 33};
        vecs[9]  = '{DIV_OP_REM,  32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 33};
        vecs[10] = '{DIV_OP_REM,  32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        33};
        vecs[11] = '{DIV_OP_DIV,  32'h80000000, 32'd2,        5'd16, 32'hC0000000, 33};
        vecs[12] = '{DIV_OP_REMU, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 33};
        vecs[13] = '{DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        33};

        repeat (3) @(negedge clk);
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        check_eq("reset done", 32'(bus.done), 32'd0);
        check_eq("reset result", bus.result, 32'd0);
        check_eq("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, bcnt);
            check_eq($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check_eq($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
            check_eq($sformatf("v%0d busy at done", i), 32'(bus.busy), 32'd0);
            check_eq($sformatf("v%0d result", i), bus.result, vecs[i].exp);
            check_eq($sformatf("v%0d rd_out", i), 32'(bus.rd_out), 32'(vecs[i].rd));
            @(negedge clk);
            check_eq($sformatf("v%0d done one cycle", i), 32'(bus.done), 32'd0);
            check_eq($sformatf("v%0d result hold", i), bus.result, vecs[i].exp);
        end

        // Non-divide op with start is ignored.
        run_op(3'b010, 32'd50, 32'd5, 5'd1, lat, bcnt);
        check_eq("ignored op done", 32'(lat), 32'd0);
        check_eq("ignored op busy", 32'(bcnt), 32'd0);
        check_eq("ignored op result", bus.result, 32'd0);

        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        drive_start(DIV_OP_DIV, 32'd1000, 32'd3, 5'd2);
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("flush busy before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_eq("flush busy after", 32'(bus.busy), 32'd0);
        count_dones(40, ndone);
        check_eq("flush no done", 32'(ndone), 32'd0);
        check_eq("flush result kept", bus.result, 32'd0);

        // Start with flush asserted is not accepted.
        @(negedge clk);
        drive_start(DIV_OP_DIVU, 32'd9, 32'd0, 5'd2);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.div_start = 1'b0;
        bus.flush     = 1'b0;
        count_dones(5, ndone);
        check_eq("flush+start no done", 32'(ndone), 32'd0);

        run_op(DIV_OP_DIV, 32'd9, 32'd3, 5'd4, lat, bcnt);
        check_eq("post-flush latency", 32'(lat), 32'd33);
        check_eq("post-flush result", bus.result, 32'd3);
        check_eq("post-flush rd_out", 32'(bus.rd_out), 32'd4);

        // Back-to-back start in the DONE cycle; a start mid-CALC is ignored.
        run_op(DIV_OP_DIV, 32'd100, 32'd7, 5'd5, lat, bcnt);
        check_eq("b2b first result", bus.result, 32'd14);
        drive_start(DIV_OP_DIVU, 32'd20, 32'd4, 5'd9);
        wait_done(5, lat, bcnt);
        check_eq("b2b latency", 32'(lat), 32'd33);
        check_eq("b2b result", bus.result, 32'd5);
        check_eq("b2b rd_out", 32'(bus.rd_out), 32'd9);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        drive_start(DIV_OP_DIV, 32'd100, 32'd7, 5'd6);
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async rst busy", 32'(bus.busy), 32'd0);
        check_eq("async rst done", 32'(bus.done), 32'd0);
        check_eq("async rst result", bus.result, 32'd0);
        check_eq("async rst rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(40, ndone);
        check_eq("async rst no done", 32'(ndone), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
